// File: rtl/lsq_issue_unit.sv
// LSQ consumer: pops queue entries, holds one request per subunit handshake, and tracks
// issued loads in an in-order response FIFO that aligns/extends returned data for writeback.
module lsq_issue_unit #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned SUBUNITS        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_lsq_valid,
    input  logic                    i_lsq_load,
    input  logic                    i_lsq_store,
    input  logic [31:0]             i_lsq_addr,
    input  logic [3:0]              i_lsq_be,
    input  logic [2:0]              i_lsq_fn3,
    input  logic [31:0]             i_lsq_data,
    input  logic [ID_W-1:0]         i_lsq_id,
    input  logic [1:0]              i_lsq_subunit,
    output logic                    o_lsq_pop,
    output logic [SUBUNITS-1:0]     o_sub_req,
    input  logic [SUBUNITS-1:0]     i_sub_ack,
    output logic [31:0]             o_sub_addr,
    output logic                    o_sub_re,
    output logic                    o_sub_we,
    output logic [3:0]              o_sub_be,
    output logic [31:0]             o_sub_wdata,
    input  logic [SUBUNITS-1:0]     i_sub_rvalid,
    input  logic [32*SUBUNITS-1:0]  i_sub_rdata,
    output logic                    o_wb_valid,
    output logic [ID_W-1:0]         o_wb_id,
    output logic [31:0]             o_wb_data,
    output logic                    o_idle
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned ENT_W = ID_W + 7;
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(MAX_OUTSTANDING);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]      r_state;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [2:0]      r_fn3;
    logic [1:0]      r_sel;
    logic [ID_W-1:0] r_id;
    logic            r_re;
    logic            r_we;

    logic [ENT_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    // Counts FIFO entries plus the load still waiting for its ack (reserved slot).
    logic [PTR_W:0]   r_count;

    logic            r_wb_valid;
    logic [ID_W-1:0] r_wb_id;
    logic [31:0]     r_wb_data;

    logic                w_ack_now;
    logic                w_full_eff;
    logic                w_pop;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_head_valid;
    logic [ENT_W-1:0]    w_head;
    logic [ID_W-1:0]     w_head_id;
    logic [2:0]          w_head_fn3;
    logic [1:0]          w_head_off;
    logic [1:0]          w_head_sub;
    logic [SUBUNITS-1:0] w_head_mask;
    logic [31:0]         w_head_rdata;
    logic [31:0]         w_shift;
    logic [31:0]         w_fmt;

    assign w_head       = r_fifo[r_rptr[PTR_W-1:0]];
    assign w_head_id    = w_head[ENT_W-1 -: ID_W];
    assign w_head_fn3   = w_head[6:4];
    assign w_head_off   = w_head[3:2];
    assign w_head_sub   = w_head[1:0];
    assign w_head_valid = (r_wptr != r_rptr);
    assign w_head_rdata = i_sub_rdata[{w_head_sub, 5'b00000} +: 32];
    assign w_shift      = w_head_rdata >> {w_head_off, 3'b000};

    assign w_ack_now   = (r_state == ST_REQ) & i_sub_ack[r_sel];
    assign w_fifo_pop  = w_head_valid & i_sub_rvalid[w_head_sub];
    assign w_fifo_push = w_ack_now & r_re;
    assign w_full_eff  = (r_count == CNT_MAX) & ~w_fifo_pop;
    assign w_pop       = i_lsq_valid & ~i_flush & ((r_state == ST_IDLE) | w_ack_now)
                       & ~(i_lsq_load & w_full_eff);

    always_comb begin
        w_fmt = w_shift;
        case (w_head_fn3)
            3'b000:  w_fmt = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_fmt = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_fmt = {24'h0, w_shift[7:0]};
            3'b101:  w_fmt = {16'h0, w_shift[15:0]};
            default: w_fmt = w_shift;
        endcase
    end

    always_comb begin
        o_sub_req = '0;
        if (r_state == ST_REQ) o_sub_req[r_sel] = 1'b1;
    end

    always_comb begin
        w_head_mask = '0;
        if (w_head_valid) w_head_mask[w_head_sub] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_fn3   <= '0;
            r_sel   <= '0;
            r_id    <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_pop) begin
            r_state <= ST_REQ;
            r_addr  <= i_lsq_addr;
            r_wdata <= i_lsq_data;
            r_be    <= i_lsq_be;
            r_fn3   <= i_lsq_fn3;
            r_sel   <= i_lsq_subunit;
            r_id    <= i_lsq_id;
            r_re    <= i_lsq_load;
            r_we    <= i_lsq_store;
        end else if (w_ack_now) begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_fifo_push) r_fifo[r_wptr[PTR_W-1:0]] <= {r_id, r_fn3, r_addr[1:0], r_sel};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifo_push) r_wptr <= r_wptr + 1'b1;
            if (w_fifo_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_pop & i_lsq_load, w_fifo_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_fifo_pop;
            if (w_fifo_pop) begin
                r_wb_id   <= w_head_id;
                r_wb_data <= w_fmt;
            end
        end
    end

    assign o_lsq_pop   = w_pop;
    assign o_sub_addr  = r_addr;
    assign o_sub_re    = r_re;
    assign o_sub_we    = r_we;
    assign o_sub_be    = r_be;
    assign o_sub_wdata = r_wdata;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_id     = r_wb_id;
    assign o_wb_data   = r_wb_data;
    assign o_idle      = (r_state == ST_IDLE) & (r_count == '0);

    // Read data may only come back from the subunit owning the oldest outstanding load.
    a_rvalid_head_only: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_sub_rvalid & ~w_head_mask) == '0);

endmodule

// File: tb/tb_lsq_issue_unit.sv
// Directed bench for lsq_issue_unit: inputs driven on the falling edge, outputs checked 1 time
// unit later, with every expected value hand-computed.
module tb_lsq_issue_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         lsq_valid;
    logic         lsq_load;
    logic         lsq_store;
    logic [31:0]  lsq_addr;
    logic [3:0]   lsq_be;
    logic [2:0]   lsq_fn3;
    logic [31:0]  lsq_data;
    logic [2:0]   lsq_id;
    logic [1:0]   lsq_subunit;
    logic         lsq_pop;
    logic [3:0]   sub_req;
    logic [3:0]   sub_ack;
    logic [31:0]  sub_addr;
    logic         sub_re;
    logic         sub_we;
    logic [3:0]   sub_be;
    logic [31:0]  sub_wdata;
    logic [3:0]   sub_rvalid;
    logic [127:0] sub_rdata;
    logic         wb_valid;
    logic [2:0]   wb_id;
    logic [31:0]  wb_data;
    logic         idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsq_issue_unit #(.MAX_OUTSTANDING(4), .ID_W(3), .SUBUNITS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_lsq_valid(lsq_valid), .i_lsq_load(lsq_load), .i_lsq_store(lsq_store),
        .i_lsq_addr(lsq_addr), .i_lsq_be(lsq_be), .i_lsq_fn3(lsq_fn3),
        .i_lsq_data(lsq_data), .i_lsq_id(lsq_id), .i_lsq_subunit(lsq_subunit),
        .o_lsq_pop(lsq_pop), .o_sub_req(sub_req), .i_sub_ack(sub_ack),
        .o_sub_addr(sub_addr), .o_sub_re(sub_re), .o_sub_we(sub_we), .o_sub_be(sub_be),
        .o_sub_wdata(sub_wdata), .i_sub_rvalid(sub_rvalid), .i_sub_rdata(sub_rdata),
        .o_wb_valid(wb_valid), .o_wb_id(wb_id), .o_wb_data(wb_data), .o_idle(idle)
    );

    task automatic drive_load(input logic [31:0] addr, input logic [2:0] fn3,
                              input logic [2:0] id, input logic [1:0] sub);
        lsq_valid = 1'b1; lsq_load = 1'b1; lsq_store = 1'b0;
        lsq_addr = addr; lsq_fn3 = fn3; lsq_id = id; lsq_subunit = sub;
        lsq_be = 4'h0; lsq_data = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (sub_req !== 4'b0)     begin bad++; $display("FAIL reset_req got=%b exp=0000", sub_req); end
        total++; if (lsq_pop !== 1'b0)     begin bad++; $display("FAIL reset_pop got=%b exp=0", lsq_pop); end
        total++; if (wb_valid !== 1'b0)    begin bad++; $display("FAIL reset_wbv got=%b exp=0", wb_valid); end
        total++; if (wb_id !== 3'd0)       begin bad++; $display("FAIL reset_wbid got=%0d exp=0", wb_id); end
        total++; if (wb_data !== 32'h0)    begin bad++; $display("FAIL reset_wbdata got=%h exp=0", wb_data); end
        total++; if (idle !== 1'b1)        begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        total++; if (sub_addr !== 32'h0)   begin bad++; $display("FAIL reset_addr got=%h exp=0", sub_addr); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_lw();
        @(negedge clk);
        drive_load(32'h104, 3'b010, 3'd5, 2'd1);
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL lw_pop got=%b exp=1", lsq_pop); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            lsq_valid = 1'b0;
            sub_ack = (c == 3) ? 4'b0010 : 4'b0000;
            #1;
            total++; if (sub_req !== 4'b0010) begin bad++; $display("FAIL lw_req c%0d got=%b exp=0010", c, sub_req); end
        end
        total++; if (sub_addr !== 32'h104 || sub_re !== 1'b1 || sub_we !== 1'b0)
            begin bad++; $display("FAIL lw_payload got=%h re=%b we=%b exp=104 re=1 we=0", sub_addr, sub_re, sub_we); end
        @(negedge clk);
        sub_ack = 4'b0;
        #1;
        total++; if (sub_req !== 4'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0000", sub_req); end
        total++; if (idle !== 1'b0)    begin bad++; $display("FAIL lw_busy got=%b exp=0", idle); end
        @(negedge clk);
        @(negedge clk);
        sub_rvalid = 4'b0010; sub_rdata = '0; sub_rdata[63:32] = 32'hDEADBEEF;
        @(negedge clk);
        sub_rvalid = 4'b0;
        #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lw_wbv got=%b exp=1", wb_valid); end
        total++; if (wb_id !== 3'd5)    begin bad++; $display("FAIL lw_wbid got=%0d exp=5", wb_id); end
        total++; if (wb_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_wbdata got=%h exp=deadbeef", wb_data); end
        @(negedge clk);
        #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_wbv_pulse got=%b exp=0", wb_valid); end
        total++; if (idle !== 1'b1)     begin bad++; $display("FAIL lw_idle got=%b exp=1", idle); end
    endtask

    task automatic test_lb_lbu();
        logic [31:0] addrs [5] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1};
        logic [2:0]  fns   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                   32'h000080FF, 32'hFFFFFFFF};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive_load(addrs[k], fns[k], 3'(k), 2'd2);
            #1;
            total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL fmt%0d_pop got=%b exp=1", k, lsq_pop); end
            @(negedge clk);
            lsq_valid = 1'b0; sub_ack = 4'b0100;
            @(negedge clk);
            sub_ack = 4'b0; sub_rvalid = 4'b0100; sub_rdata = '0; sub_rdata[95:64] = 32'h80FFFF00;
            @(negedge clk);
            sub_rvalid = 4'b0;
            #1;
            total++; if (wb_valid !== 1'b1 || wb_id !== 3'(k) || wb_data !== exps[k])
                begin bad++; $display("FAIL fmt%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                                      k, wb_valid, wb_id, wb_data, k, exps[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] bes [4] = '{4'b0001, 4'b0011, 4'b1100, 4'b1111};
        @(negedge clk);
        sub_ack = 4'b0001;
        lsq_valid = 1'b1; lsq_load = 1'b0; lsq_store = 1'b1; lsq_subunit = 2'd0;
        lsq_fn3 = 3'b010; lsq_id = 3'd0;
        lsq_addr = 32'h10; lsq_be = bes[0]; lsq_data = 32'hA0A00000;
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL b2b_pop0 got=%b exp=1", lsq_pop); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                lsq_addr = 32'h10 + 32'(4 * k); lsq_be = bes[k]; lsq_data = 32'hA0A00000 + 32'(k);
            end else begin
                lsq_valid = 1'b0;
            end
            #1;
            if (k < 4) begin
                total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL b2b_pop%0d got=%b exp=1", k, lsq_pop); end
            end
            total++; if (sub_req !== 4'b0001 || sub_we !== 1'b1 || sub_re !== 1'b0)
                begin bad++; $display("FAIL b2b_req%0d got=%b we=%b re=%b exp=0001 we=1 re=0",
                                      k - 1, sub_req, sub_we, sub_re); end
            total++; if (sub_addr !== 32'h10 + 32'(4 * (k - 1)) || sub_be !== bes[k - 1]
                         || sub_wdata !== 32'hA0A00000 + 32'(k - 1))
                begin bad++; $display("FAIL b2b_data%0d got a=%h be=%b d=%h", k - 1,
                                      sub_addr, sub_be, sub_wdata); end
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_wbv%0d got=%b exp=0", k, wb_valid); end
        end
        @(negedge clk);
        sub_ack = 4'b0;
        #1;
        total++; if (sub_req !== 4'b0 || wb_valid !== 1'b0 || idle !== 1'b1)
            begin bad++; $display("FAIL b2b_end got req=%b wbv=%b idle=%b exp 0000 0 1", sub_req, wb_valid, idle); end
    endtask

    task automatic test_outstanding();
        @(negedge clk);
        sub_ack = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            drive_load(32'h200 + 32'(4 * i), 3'b010, 3'(i), 2'd3);
            #1;
            total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL lim_pop%0d got=%b exp=1", i, lsq_pop); end
            @(negedge clk);
        end
        drive_load(32'h210, 3'b010, 3'd4, 2'd3);
        #1;
        total++; if (lsq_pop !== 1'b0) begin bad++; $display("FAIL lim_block1 got=%b exp=0", lsq_pop); end
        @(negedge clk);
        #1;
        total++; if (lsq_pop !== 1'b0) begin bad++; $display("FAIL lim_block2 got=%b exp=0", lsq_pop); end
        @(negedge clk);
        sub_rvalid = 4'b1000; sub_rdata = '0; sub_rdata[127:96] = 32'h11111111;
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL lim_release got=%b exp=1", lsq_pop); end
        @(negedge clk);
        lsq_valid = 1'b0; sub_rvalid = 4'b0;
        #1;
        total++; if (wb_valid !== 1'b1 || wb_id !== 3'd0 || wb_data !== 32'h11111111)
            begin bad++; $display("FAIL lim_wb0 got v=%b id=%0d d=%h exp 1 0 11111111", wb_valid, wb_id, wb_data); end
        total++; if (sub_req !== 4'b1000 || sub_addr !== 32'h210)
            begin bad++; $display("FAIL lim_req4 got=%b a=%h exp=1000 a=210", sub_req, sub_addr); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sub_rvalid = 4'b1000; sub_rdata[127:96] = 32'h20000000 + 32'(k);
            @(negedge clk);
            sub_rvalid = 4'b0;
            #1;
            total++; if (wb_valid !== 1'b1 || wb_id !== 3'(k) || wb_data !== 32'h20000000 + 32'(k))
                begin bad++; $display("FAIL lim_wb%0d got v=%b id=%0d d=%h", k, wb_valid, wb_id, wb_data); end
        end
        sub_ack = 4'b0;
        #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL lim_idle got=%b exp=1", idle); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_load(32'h300, 3'b010, 3'd6, 2'd1);
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL fl_pop6 got=%b exp=1", lsq_pop); end
        @(negedge clk);
        sub_ack = 4'b0010;
        drive_load(32'h304, 3'b010, 3'd7, 2'd2);
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL fl_pop7 got=%b exp=1", lsq_pop); end
        @(negedge clk);
        sub_ack = 4'b0100; flush = 1'b1;
        lsq_load = 1'b0; lsq_store = 1'b1; lsq_subunit = 2'd0;
        #1;
        total++; if (lsq_pop !== 1'b0) begin bad++; $display("FAIL fl_block_ack got=%b exp=0", lsq_pop); end
        @(negedge clk);
        sub_ack = 4'b0;
        #1;
        total++; if (lsq_pop !== 1'b0 || sub_req !== 4'b0)
            begin bad++; $display("FAIL fl_block_idle got pop=%b req=%b exp 0 0000", lsq_pop, sub_req); end
        @(negedge clk);
        sub_rvalid = 4'b0010; sub_rdata = '0; sub_rdata[63:32] = 32'h66666666;
        #1;
        total++; if (lsq_pop !== 1'b0) begin bad++; $display("FAIL fl_block_rsp got=%b exp=0", lsq_pop); end
        @(negedge clk);
        sub_rvalid = 4'b0100; sub_rdata[95:64] = 32'h77777777;
        #1;
        total++; if (wb_valid !== 1'b1 || wb_id !== 3'd6 || wb_data !== 32'h66666666)
            begin bad++; $display("FAIL fl_wb6 got v=%b id=%0d d=%h exp 1 6 66666666", wb_valid, wb_id, wb_data); end
        @(negedge clk);
        sub_rvalid = 4'b0;
        #1;
        total++; if (wb_valid !== 1'b1 || wb_id !== 3'd7 || wb_data !== 32'h77777777)
            begin bad++; $display("FAIL fl_wb7 got v=%b id=%0d d=%h exp 1 7 77777777", wb_valid, wb_id, wb_data); end
        total++; if (lsq_pop !== 1'b0) begin bad++; $display("FAIL fl_block_end got=%b exp=0", lsq_pop); end
        @(negedge clk);
        lsq_valid = 1'b0; flush = 1'b0;
        #1;
        total++; if (wb_valid !== 1'b0 || idle !== 1'b1)
            begin bad++; $display("FAIL fl_end got wbv=%b idle=%b exp 0 1", wb_valid, idle); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_load(32'h400, 3'b010, 3'd1, 2'd1);
        @(negedge clk);
        lsq_valid = 1'b0; sub_ack = 4'b0010;
        @(negedge clk);
        sub_ack = 4'b0;
        drive_load(32'h404, 3'b010, 3'd2, 2'd1);
        #1;
        total++; if (lsq_pop !== 1'b1) begin bad++; $display("FAIL ar_pop got=%b exp=1", lsq_pop); end
        @(negedge clk);
        lsq_valid = 1'b0;
        #1;
        total++; if (sub_req !== 4'b0010 || idle !== 1'b0)
            begin bad++; $display("FAIL ar_pre got req=%b idle=%b exp 0010 0", sub_req, idle); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (sub_req !== 4'b0) begin bad++; $display("FAIL ar_req_async got=%b exp=0000", sub_req); end
        total++; if (idle !== 1'b1)    begin bad++; $display("FAIL ar_idle_async got=%b exp=1", idle); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (idle !== 1'b1 || sub_req !== 4'b0 || wb_valid !== 1'b0)
            begin bad++; $display("FAIL ar_release got idle=%b req=%b wbv=%b", idle, sub_req, wb_valid); end
        @(negedge clk);
        drive_load(32'h500, 3'b010, 3'd3, 2'd0);
        @(negedge clk);
        lsq_valid = 1'b0; sub_ack = 4'b0001;
        @(negedge clk);
        sub_ack = 4'b0; sub_rvalid = 4'b0001; sub_rdata = '0; sub_rdata[31:0] = 32'h33333333;
        @(negedge clk);
        sub_rvalid = 4'b0;
        #1;
        total++; if (wb_valid !== 1'b1 || wb_id !== 3'd3 || wb_data !== 32'h33333333)
            begin bad++; $display("FAIL ar_after got v=%b id=%0d d=%h exp 1 3 33333333", wb_valid, wb_id, wb_data); end
    endtask

    initial begin
        flush = 1'b0; lsq_valid = 1'b0; lsq_load = 1'b0; lsq_store = 1'b0;
        lsq_addr = '0; lsq_be = '0; lsq_fn3 = '0; lsq_data = '0; lsq_id = '0; lsq_subunit = '0;
        sub_ack = '0; sub_rvalid = '0; sub_rdata = '0;
        test_reset();
        test_single_lw();
        test_lb_lbu();
        test_back_to_back();
        test_outstanding();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
